// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor for the SB_PLL40_CORE wrapper, reference-clock domain.
// Holds the PLL in reset, waits for a stable lock, then releases the system reset.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 1200,
  parameter int unsigned STABLE_CYCLES  = 120,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned CNT_W          = 12
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       LOCK,
  output logic       PLL_RESETB,
  output logic       SYS_RESETN,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [3:0] RETRY_COUNT,
  output logic [7:0] LOSS_COUNT
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM    = RETRY_W'(RETRY_MAX);
  localparam logic [LOSS_W-1:0]  LOSS_SAT     = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e               state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [1:0]           sync_q,       sync_d;
  logic                 pll_resetb_q, pll_resetb_d;
  logic                 sys_resetn_q, sys_resetn_d;
  logic                 locked_q,     locked_d;
  logic                 fault_q,      fault_d;
  logic [RETRY_W-1:0]   retry_q,      retry_d;
  logic [LOSS_W-1:0]    loss_q,       loss_d;
  logic                 lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock
  assign sync_d = {sync_q[0], LOCK};
  assign lock_s = sync_q[1];

  always_ff @(posedge REFERENCECLK) begin
    if (!RESET) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      sync_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= '0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      pll_resetb_q <= pll_resetb_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pll_resetb_d = pll_resetb_q;
    sys_resetn_d = sys_resetn_q;
    locked_d     = locked_q;
    fault_d      = fault_q;
    retry_d      = retry_q;
    loss_d       = loss_q;

    unique case (state_q)
      ST_PLL_RST: begin
        pll_resetb_d = 1'b0;
        sys_resetn_d = 1'b0;
        locked_d     = 1'b0;
        if (cnt_q == RST_LAST) begin
          state_d      = ST_WAIT_LOCK;
          cnt_d        = '0;
          pll_resetb_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A lock seen on the timeout edge takes priority over the retry
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d        = '0;
          pll_resetb_d = 1'b0;
          if (retry_q == RETRY_LIM) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = ST_PLL_RST;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d      = ST_RUN;
          cnt_d        = '0;
          sys_resetn_d = 1'b1;
          locked_d     = 1'b1;
          retry_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lock loss: fall back to waiting without re-resetting the PLL
      ST_RUN: begin
        if (!lock_s) begin
          state_d      = ST_WAIT_LOCK;
          cnt_d        = '0;
          sys_resetn_d = 1'b0;
          locked_d     = 1'b0;
          if (loss_q != LOSS_SAT) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end

      ST_FAULT: begin
        pll_resetb_d = 1'b0;
        sys_resetn_d = 1'b0;
        locked_d     = 1'b0;
        fault_d      = 1'b1;
        retry_d      = RETRY_LIM;
      end

      default: begin
        state_d      = ST_PLL_RST;
        cnt_d        = '0;
        pll_resetb_d = 1'b0;
        sys_resetn_d = 1'b0;
        locked_d     = 1'b0;
      end
    endcase
  end

  assign PLL_RESETB  = pll_resetb_q;
  assign SYS_RESETN  = sys_resetn_q;
  assign LOCKED      = locked_q;
  assign FAULT       = fault_q;
  assign RETRY_COUNT = retry_q;
  assign LOSS_COUNT  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected output vectors are queued per
// driven cycle and compared against the DUT one step later.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       locked;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;
  logic [15:0] obs;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .RETRY_MAX     (2),
    .CNT_W         (12)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (rst_n),
    .LOCK        (lock),
    .PLL_RESETB  (pll_resetb),
    .SYS_RESETN  (sys_resetn),
    .LOCKED      (locked),
    .FAULT       (fault),
    .RETRY_COUNT (retry_count),
    .LOSS_COUNT  (loss_count)
  );

  assign obs = {pll_resetb, sys_resetn, locked, fault, retry_count, loss_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic rb, input logic sr, input logic lk,
                                     input logic ft, input int unsigned rc,
                                     input int unsigned lc);
    return {rb, sr, lk, ft, 4'(rc), 8'(lc)};
  endfunction

  task automatic check_head();
    exp_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed={rb,sr,lk,ft,rc,lc}=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // Queue the expectation for the coming edge, advance one cycle, compare
  task automatic step(input string tag, input logic [15:0] exp_val);
    exp_t e;
    e.tag = tag;
    e.val = exp_val;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    int exp_loss;
    rst_n = 1'b0;
    lock  = 1'b0;

    // Reset values
    repeat (2) step("reset", pk(0, 0, 0, 0, 0, 0));

    // Plan 1: first lock sequence
    rst_n = 1'b1;
    repeat (3) step("t1_pllrst_low", pk(0, 0, 0, 0, 0, 0));
    step("t1_pllrst_rise", pk(1, 0, 0, 0, 0, 0));
    repeat (5) step("t1_wait", pk(1, 0, 0, 0, 0, 0));
    lock = 1'b1;
    repeat (10) step("t1_not_yet", pk(1, 0, 0, 0, 0, 0));
    step("t1_release", pk(1, 1, 1, 0, 0, 0));

    // Plan 4: lock losses in RUN, saturating at 255
    exp_loss = 0;
    for (int i = 0; i < 300; i++) begin
      lock = 1'b0;
      repeat (2) step("t4_drop_hold", pk(1, 1, 1, 0, 0, exp_loss));
      exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
      step("t4_fall", pk(1, 0, 0, 0, 0, exp_loss));
      if (i == 0) repeat (3) step("t4_wait", pk(1, 0, 0, 0, 0, exp_loss));
      lock = 1'b1;
      repeat (10) step("t4_relock", pk(1, 0, 0, 0, 0, exp_loss));
      step("t4_rerelease", pk(1, 1, 1, 0, 0, exp_loss));
    end

    // Plan 5a: reset while in STABLE
    lock = 1'b0;
    repeat (2) step("t5_drop_hold", pk(1, 1, 1, 0, 0, 255));
    step("t5_fall_sat", pk(1, 0, 0, 0, 0, 255));
    lock = 1'b1;
    repeat (3) step("t5_to_stable", pk(1, 0, 0, 0, 0, 255));
    rst_n = 1'b0;
    lock  = 1'b0;
    step("t5_rst_in_stable", pk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Plan 3: lock glitch during STABLE
    repeat (3) step("t3_pllrst_low", pk(0, 0, 0, 0, 0, 0));
    step("t3_pllrst_rise", pk(1, 0, 0, 0, 0, 0));
    lock = 1'b1;
    repeat (5) step("t3_first_high", pk(1, 0, 0, 0, 0, 0));
    lock = 1'b0;
    repeat (3) step("t3_glitch_low", pk(1, 0, 0, 0, 0, 0));
    lock = 1'b1;
    repeat (10) step("t3_second_high", pk(1, 0, 0, 0, 0, 0));
    step("t3_release", pk(1, 1, 1, 0, 0, 0));

    // Plan 2: no lock ever, retries then FAULT
    rst_n = 1'b0;
    lock  = 1'b0;
    step("t2_reset", pk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int a = 0; a <= 2; a++) begin
      repeat (3) step("t2_low", pk(0, 0, 0, 0, a, 0));
      step("t2_rise", pk(1, 0, 0, 0, a, 0));
      repeat (19) step("t2_window", pk(1, 0, 0, 0, a, 0));
      if (a < 2) step("t2_retry", pk(0, 0, 0, 0, a + 1, 0));
      else       step("t2_fault", pk(0, 0, 0, 1, 2, 0));
    end
    lock = 1'b1;
    repeat (10) step("t2_fault_hold", pk(0, 0, 0, 1, 2, 0));

    // Plan 5b: reset while in FAULT
    rst_n = 1'b0;
    lock  = 1'b0;
    step("t5_rst_in_fault", pk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Plan 6: lock arrives exactly on the timeout edge with one retry used
    repeat (3) step("t6_low", pk(0, 0, 0, 0, 0, 0));
    step("t6_rise", pk(1, 0, 0, 0, 0, 0));
    repeat (19) step("t6_window0", pk(1, 0, 0, 0, 0, 0));
    step("t6_retry1", pk(0, 0, 0, 0, 1, 0));
    repeat (3) step("t6_low1", pk(0, 0, 0, 0, 1, 0));
    step("t6_rise1", pk(1, 0, 0, 0, 1, 0));
    repeat (17) step("t6_window1", pk(1, 0, 0, 0, 1, 0));
    lock = 1'b1;
    repeat (2) step("t6_sync", pk(1, 0, 0, 0, 1, 0));
    step("t6_lock_wins", pk(1, 0, 0, 0, 1, 0));
    repeat (7) step("t6_stable", pk(1, 0, 0, 0, 1, 0));
    step("t6_release", pk(1, 1, 1, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
